tt_uart_tx: RTL
===============

# tt_uart_tx

Byte-to-serial UART transmitter (8N1) with a small input FIFO. It sits directly downstream of the user project logic inside the TinyTapeout top: the project pushes result bytes through a valid/ready port, and the block drives one dedicated output pin (e.g. `uo_out[0]`) as the serial line. Frames are sent back-to-back while data is queued. The block is gated by the tile `ena`.

## Interface
Parameters:
- `CLK_DIV`, default 104: clock cycles per bit. Legal range 2..65535; counter width is derived from it.
- `FIFO_DEPTH`, default 4: queue entries. Must be a power of two, 2..16.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  tile enable; 0 blocks new writes and new frame starts.
- `wr_data`  in  8  byte to transmit.
- `wr_valid`  in  1  producer offers `wr_data`.
- `wr_ready`  out  1  combinational: `ena && fifo_count < FIFO_DEPTH`.
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  registered; 1 while a frame is in progress.
- `fifo_count`  out  clog2(FIFO_DEPTH)+1  bytes queued, registered; excludes the byte being shifted.

## Operation
- Write handshake: a byte is accepted on a rising edge where `wr_valid && wr_ready`. The FIFO is circular and uses wrapping read and write pointers.
- State machine: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1 and `busy`=0. If `ena` and `fifo_count>0`, pop the head byte into the shift register and go to START.
  - START: `tx`=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: `tx` = shift[0], sent LSB first. After each bit, shift right. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLK_DIV cycles. At the end of STOP:
    - if `ena` and `fifo_count>0`, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Baud counter: runs 0..CLK_DIV-1 and is cleared on every state change. A bit ends on the edge where the counter equals CLK_DIV-1.
- Simultaneous push and pop on one edge: both take effect and `fifo_count` is unchanged.
  - When full, `wr_ready`=0 even if a pop happens that cycle. There is no pass-through.
- `ena` falling mid-frame: the current frame completes. No further pops occur, and queued bytes are kept.
- Reset: asynchronous; takes effect mid-frame and mid-write.
  - `tx`=1, `busy`=0, `fifo_count`=0, state=IDLE, pointers=0, counters=0.
  - `wr_ready` then equals `ena`.
  - Any partially sent frame is abandoned.

## Timing
- Write-to-line latency from IDLE with an empty FIFO:
  - byte accepted at edge N, `fifo_count`=1 after N;
  - pop and START entry at edge N+1, so `tx` falls and `busy` rises after N+1;
  - `fifo_count` returns to 0 after N+1.
- Frame length: exactly 10*CLK_DIV cycles from the `tx` falling edge to the next START (back-to-back) or to IDLE.
- `busy` falls on the edge that ends STOP, and only if no new frame starts.
- Throughput: one byte per 10*CLK_DIV cycles, sustained.
- All outputs except `wr_ready` change only on rising `clk` or asynchronously on reset.

## Test plan
Directed scenarios use CLK_DIV=4 and FIFO_DEPTH=4.
- Reset state: assert `rst_n`=0 mid-frame → `tx`=1, `busy`=0, `fifo_count`=0 immediately; `wr_ready`=`ena` after release.
- Single byte: write 0xA5 at edge N →
  - `tx` low for cycles N+1..N+4;
  - data bits 1,0,1,0,0,1,0,1, each 4 cycles wide;
  - stop high for 4 cycles;
  - `busy`=0 after edge N+41.
- Back-to-back: write 0x00 then 0xFF on consecutive edges →
  - second START begins on the edge ending the first STOP, with no idle cycles;
  - total `busy` time is 80 cycles.
- Full FIFO: with a frame in progress, push 4 bytes → `fifo_count`=4 and `wr_ready`=0. A fifth `wr_valid` is not accepted. After the next pop, `wr_ready`=1.
- Simultaneous push/pop: `fifo_count`=2 and a push on the same edge as the end-of-STOP pop → `fifo_count` stays 2.
- Enable gating: drop `ena` mid-frame with 2 bytes queued →
  - current frame completes and then IDLE, with `fifo_count`=2 held;
  - restore `ena` → next START on the following edge.

Source files
------------

// File: rtl/tt_uart_tx.sv
// tt_uart_tx: 8N1 UART transmitter with a small circular input FIFO.
//
// The project logic pushes bytes through a valid/ready port. Frames are sent
// back-to-back while bytes are queued. The tile enable `ena` blocks new writes
// and new frame starts, but a frame already on the line always completes.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   ena        in   tile enable
//   wr_data    in   [7:0] byte to transmit
//   wr_valid   in   producer offers wr_data
//   wr_ready   out  combinational, ena && fifo_count < FIFO_DEPTH
//   tx         out  serial line, idle high, registered
//   busy       out  registered, high while a frame is in progress
//   fifo_count out  bytes queued (excludes the byte being shifted), registered
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | line high, waiting for ena and a queued byte
// START | start bit (low) for CLK_DIV cycles
// DATA  | eight data bits, LSB first, CLK_DIV cycles each
// STOP  | stop bit (high) for CLK_DIV cycles; may chain into START
module tt_uart_tx #(
  parameter int CLK_DIV    = 104,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CW-1:0]    DEPTH    = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   baud_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift, shift_nxt;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               push, pop, can_pop, bit_end;
  logic               tx_nxt, busy_nxt;

  assign bit_end  = (baud_cnt == BIT_LAST);
  // Full means not ready, even if a pop happens this cycle: no pass-through.
  assign wr_ready = ena && (fifo_count < DEPTH);
  assign push     = wr_valid && wr_ready;
  assign can_pop  = ena && (fifo_count != '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (can_pop) state_nxt = S_START;
      S_START: if (bit_end) state_nxt = S_DATA;
      S_DATA:  if (bit_end && (bit_idx == 3'd7)) state_nxt = S_STOP;
      S_STOP:  if (bit_end) state_nxt = can_pop ? S_START : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: pop decision, shifter update and the next registered line
  // value. tx is derived from the next state so it is glitch-free and changes
  // on the same edge as the state.
  always_comb begin
    pop       = 1'b0;
    shift_nxt = shift;
    case (state)
      S_IDLE:  pop = can_pop;
      S_DATA:  if (bit_end) shift_nxt = {1'b0, shift[7:1]};
      S_STOP:  pop = bit_end && can_pop;
      default: pop = 1'b0;
    endcase
    if (pop) shift_nxt = mem[rd_ptr];

    case (state_nxt)
      S_START: tx_nxt = 1'b0;
      S_DATA:  tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx         <= 1'b1;
      busy       <= 1'b0;
      shift      <= '0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      tx    <= tx_nxt;
      busy  <= busy_nxt;
      shift <= shift_nxt;

      // Counter restarts at every state change and at every bit boundary.
      if ((state_nxt != state) || bit_end || (state == S_IDLE))
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + 1'b1;

      if (state == S_START)
        bit_idx <= '0;
      else if ((state == S_DATA) && bit_end)
        bit_idx <= bit_idx + 3'd1;

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      // Power-of-two depth: pointers wrap naturally.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Queue storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule
